// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: turns a valid/ready command into one APB
// SETUP/ACCESS transfer and returns a one-cycle response pulse per command.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  // A zero timeout still needs a one-bit counter so the logic stays legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_waitCnt;
  logic                  r_cmdReady;
  logic                  r_rspValid;
  logic [DATA_WIDTH-1:0] r_rspRdata;
  logic                  r_rspErr;
  logic                  r_rspTimeout;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;

  logic [CNT_W-1:0]      w_waitCntNext;
  logic                  w_timeoutHit;

  // Saturating wait counter; the abort fires on the edge it would reach the limit.
  assign w_waitCntNext = (r_waitCnt == '1) ? r_waitCnt : r_waitCnt + CNT_W'(1);
  assign w_timeoutHit  = (TIMEOUT_CYCLES != 0) && (w_waitCntNext == TIMEOUT_VAL);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state      <= ST_IDLE;
      r_waitCnt    <= '0;
      r_cmdReady   <= 1'b1;
      r_rspValid   <= 1'b0;
      r_rspRdata   <= '0;
      r_rspErr     <= 1'b0;
      r_rspTimeout <= 1'b0;
      r_paddr      <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
    end else begin
      r_rspValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_cmdReady) begin
            r_paddr    <= cmd_addr;
            r_pwrite   <= cmd_write;
            r_pwdata   <= cmd_wdata;
            r_psel     <= 1'b1;
            r_penable  <= 1'b0;
            r_cmdReady <= 1'b0;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_waitCnt <= '0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            r_rspRdata   <= (r_pwrite || PSLVERR) ? '0 : PRDATA;
            r_rspErr     <= PSLVERR;
            r_rspTimeout <= 1'b0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_rspValid   <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_waitCnt <= w_waitCntNext;
            if (w_timeoutHit) begin
              r_rspRdata   <= '0;
              r_rspErr     <= 1'b1;
              r_rspTimeout <= 1'b1;
              r_psel       <= 1'b0;
              r_penable    <= 1'b0;
              r_rspValid   <= 1'b1;
              r_state      <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          r_cmdReady <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_cmdReady <= 1'b1;
          r_psel     <= 1'b0;
          r_penable  <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmdReady;
  assign rsp_valid   = r_rspValid;
  assign rsp_rdata   = r_rspRdata;
  assign rsp_err     = r_rspErr;
  assign rsp_timeout = r_rspTimeout;
  assign PADDR       = r_paddr;
  assign PSELx       = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PWDATA      = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a small scripted APB slave plus one
// task per scenario, each checking its own hand-computed expectations.
module tb_apb_master_bridge;

  localparam int K = 8;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [3:0] cmd_addr = 4'h0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic [3:0] PADDR;
  logic       PSELx;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic       PREADY = 1'b0;
  logic [7:0] PRDATA = 8'h00;
  logic       PSLVERR = 1'b0;

  int cmpCnt = 0;
  int errCnt = 0;

  // Scripted slave behaviour knobs.
  int       slvWait = 0;
  logic [7:0] slvRdata = 8'h00;
  logic     slvErr = 1'b0;
  bit       slvStall = 1'b0;
  bit       slvEarly = 1'b0;
  int       accCnt = 0;

  // Results of the most recent runCmd.
  bit         rHs, rGot, rStable, rSetupEn;
  int         rLat, rSel, rEn;
  logic [7:0] rRdata;
  logic       rErr, rTmo, rReadyAtRsp, rValidAfter, rReadyAfter;

  apb_master_bridge #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(K)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR(PADDR),
    .PSELx(PSELx),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PWDATA(PWDATA),
    .PREADY(PREADY),
    .PRDATA(PRDATA),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Slave answers slvWait ACCESS cycles late; slvEarly drives a bogus ready in SETUP.
  always @(posedge PCLK) begin
    #1;
    if (PSELx && PENABLE) begin
      if (!slvStall && accCnt == slvWait) begin
        PREADY = 1'b1; PRDATA = slvRdata; PSLVERR = slvErr;
      end else begin
        PREADY = 1'b0; PRDATA = 8'hEE; PSLVERR = slvErr;
      end
      accCnt++;
    end else if (PSELx && slvEarly) begin
      PREADY = 1'b1; PRDATA = 8'hBD; PSLVERR = 1'b1; accCnt = 0;
    end else begin
      PREADY = 1'b0; PRDATA = 8'h00; PSLVERR = 1'b0; accCnt = 0;
    end
  end

  task automatic runCmd(input logic wr, input logic [3:0] addr, input logic [7:0] wd);
    bit hs;
    bit seenSel;
    hs = 0; seenSel = 0;
    rGot = 0; rLat = 0; rSel = 0; rEn = 0; rStable = 1; rSetupEn = 0;
    rRdata = 8'hxx; rErr = 1'bx; rTmo = 1'bx; rReadyAtRsp = 1'bx;
    @(posedge PCLK); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    for (int i = 0; i < 10 && !hs; i++) begin
      @(negedge PCLK);
      hs = cmd_ready;
    end
    rHs = hs;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wd;
    for (int n = 1; n <= 30 && !rGot; n++) begin
      @(negedge PCLK);
      if (PSELx) begin
        if (!seenSel) rSetupEn = PENABLE;
        seenSel = 1;
        rSel++;
        if (PADDR !== addr || PWRITE !== wr || PWDATA !== wd) rStable = 0;
      end
      if (PENABLE) rEn++;
      if (rsp_valid) begin
        rGot = 1; rLat = n; rRdata = rsp_rdata; rErr = rsp_err; rTmo = rsp_timeout;
        rReadyAtRsp = cmd_ready;
      end
    end
    @(negedge PCLK);
    rValidAfter = rsp_valid;
    rReadyAfter = cmd_ready;
  endtask

  task automatic test_reset();
    #12;
    cmpCnt++; if (cmd_ready !== 1'b1) begin errCnt++; $display("[TB] FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
    cmpCnt++; if (rsp_valid !== 1'b0) begin errCnt++; $display("[TB] FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    cmpCnt++; if (rsp_rdata !== 8'h00) begin errCnt++; $display("[TB] FAIL rst_rsp_rdata: got %h expected 00", rsp_rdata); end
    cmpCnt++; if (rsp_err !== 1'b0) begin errCnt++; $display("[TB] FAIL rst_rsp_err: got %b expected 0", rsp_err); end
    cmpCnt++; if (rsp_timeout !== 1'b0) begin errCnt++; $display("[TB] FAIL rst_rsp_timeout: got %b expected 0", rsp_timeout); end
    cmpCnt++; if (PADDR !== 4'h0) begin errCnt++; $display("[TB] FAIL rst_paddr: got %h expected 0", PADDR); end
    cmpCnt++; if (PSELx !== 1'b0) begin errCnt++; $display("[TB] FAIL rst_psel: got %b expected 0", PSELx); end
    cmpCnt++; if (PENABLE !== 1'b0) begin errCnt++; $display("[TB] FAIL rst_penable: got %b expected 0", PENABLE); end
    cmpCnt++; if (PWRITE !== 1'b0) begin errCnt++; $display("[TB] FAIL rst_pwrite: got %b expected 0", PWRITE); end
    cmpCnt++; if (PWDATA !== 8'h00) begin errCnt++; $display("[TB] FAIL rst_pwdata: got %h expected 00", PWDATA); end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
  endtask

  task automatic test_write_zero_wait();
    slvWait = 0; slvRdata = 8'hC7;
    runCmd(1'b1, 4'h4, 8'h83);
    cmpCnt++; if (!(rHs && rGot)) begin errCnt++; $display("[TB] FAIL wr_handshake_rsp: hs=%b rsp=%b expected 1/1", rHs, rGot); end
    cmpCnt++; if (rLat !== 3) begin errCnt++; $display("[TB] FAIL wr_latency: got %0d expected 3", rLat); end
    cmpCnt++; if (rSel !== 2) begin errCnt++; $display("[TB] FAIL wr_psel_cycles: got %0d expected 2", rSel); end
    cmpCnt++; if (rEn !== 1 || rSetupEn !== 1'b0) begin errCnt++; $display("[TB] FAIL wr_penable: cycles=%0d setup=%b expected 1/0", rEn, rSetupEn); end
    cmpCnt++; if (rStable !== 1'b1) begin errCnt++; $display("[TB] FAIL wr_addr_data_stable: got %b expected 1", rStable); end
    cmpCnt++; if (rRdata !== 8'h00 || rErr !== 1'b0 || rTmo !== 1'b0) begin errCnt++; $display("[TB] FAIL wr_rsp: rdata=%h err=%b tmo=%b expected 00/0/0", rRdata, rErr, rTmo); end
    cmpCnt++; if (rReadyAtRsp !== 1'b0) begin errCnt++; $display("[TB] FAIL wr_ready_in_resp: got %b expected 0", rReadyAtRsp); end
    cmpCnt++; if (rValidAfter !== 1'b0 || rReadyAfter !== 1'b1) begin errCnt++; $display("[TB] FAIL wr_after_resp: valid=%b ready=%b expected 0/1", rValidAfter, rReadyAfter); end
  endtask

  task automatic test_read_one_wait();
    slvWait = 1; slvRdata = 8'h55;
    runCmd(1'b0, 4'h2, 8'h00);
    cmpCnt++; if (rLat !== 4) begin errCnt++; $display("[TB] FAIL rd1_latency: got %0d expected 4", rLat); end
    cmpCnt++; if (rSel !== 3 || rEn !== 2) begin errCnt++; $display("[TB] FAIL rd1_apb_cycles: sel=%0d en=%0d expected 3/2", rSel, rEn); end
    cmpCnt++; if (rRdata !== 8'h55 || rErr !== 1'b0 || rTmo !== 1'b0) begin errCnt++; $display("[TB] FAIL rd1_rsp: rdata=%h err=%b tmo=%b expected 55/0/0", rRdata, rErr, rTmo); end
    slvWait = 0;
  endtask

  task automatic test_slave_error();
    slvWait = 0; slvErr = 1'b1; slvEarly = 1'b1; slvRdata = 8'h3C;
    runCmd(1'b0, 4'hC, 8'h00);
    cmpCnt++; if (rLat !== 3) begin errCnt++; $display("[TB] FAIL err_latency: got %0d expected 3", rLat); end
    cmpCnt++; if (rRdata !== 8'h00 || rErr !== 1'b1 || rTmo !== 1'b0) begin errCnt++; $display("[TB] FAIL err_rsp: rdata=%h err=%b tmo=%b expected 00/1/0", rRdata, rErr, rTmo); end
    slvErr = 1'b0; slvEarly = 1'b0;
  endtask

  task automatic test_timeout();
    slvStall = 1'b1;
    runCmd(1'b0, 4'h6, 8'h00);
    cmpCnt++; if (rLat !== K + 2) begin errCnt++; $display("[TB] FAIL tmo_latency: got %0d expected %0d", rLat, K + 2); end
    cmpCnt++; if (rSel !== K + 1 || rEn !== K) begin errCnt++; $display("[TB] FAIL tmo_apb_cycles: sel=%0d en=%0d expected %0d/%0d", rSel, rEn, K + 1, K); end
    cmpCnt++; if (rRdata !== 8'h00 || rErr !== 1'b1 || rTmo !== 1'b1) begin errCnt++; $display("[TB] FAIL tmo_rsp: rdata=%h err=%b tmo=%b expected 00/1/1", rRdata, rErr, rTmo); end
    slvStall = 1'b0; slvRdata = 8'h81;
    runCmd(1'b0, 4'h1, 8'h00);
    cmpCnt++; if (rLat !== 3 || rRdata !== 8'h81 || rErr !== 1'b0 || rTmo !== 1'b0) begin errCnt++; $display("[TB] FAIL tmo_next_cmd: lat=%0d rdata=%h err=%b tmo=%b expected 3/81/0/0", rLat, rRdata, rErr, rTmo); end
  endtask

  task automatic test_back_to_back();
    logic       wrTab [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] adTab [3] = '{4'h0, 4'h8, 4'hC};
    logic [7:0] wdTab [3] = '{8'h55, 8'h00, 8'h03};
    logic [7:0] expRd [3] = '{8'h00, 8'hA7, 8'h00};
    int   hsN [3];
    int   rsN [3];
    logic [7:0] gotRd [3];
    int   hsCnt, rsCnt, selRise, selTot, idx;
    bit   hs, prevSel, orderOk, spacingOk;
    hsCnt = 0; rsCnt = 0; selRise = 0; selTot = 0; idx = 0; prevSel = 0;
    slvWait = 0; slvRdata = 8'hA7;
    @(posedge PCLK); #1;
    cmd_valid = 1'b1; cmd_write = wrTab[0]; cmd_addr = adTab[0]; cmd_wdata = wdTab[0];
    for (int n = 0; n < 40 && rsCnt < 3; n++) begin
      @(negedge PCLK);
      hs = cmd_valid && cmd_ready;
      if (PSELx) selTot++;
      if (PSELx && !prevSel) selRise++;
      prevSel = PSELx;
      if (rsp_valid) begin
        if (rsCnt < 3) begin rsN[rsCnt] = n; gotRd[rsCnt] = rsp_rdata; end
        rsCnt++;
      end
      @(posedge PCLK); #1;
      if (hs) begin
        if (hsCnt < 3) hsN[hsCnt] = n;
        hsCnt++;
        idx++;
        if (idx < 3) begin
          cmd_write = wrTab[idx]; cmd_addr = adTab[idx]; cmd_wdata = wdTab[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    cmpCnt++; if (hsCnt !== 3) begin errCnt++; $display("[TB] FAIL b2b_handshakes: got %0d expected 3", hsCnt); end
    cmpCnt++; if (rsCnt !== 3) begin errCnt++; $display("[TB] FAIL b2b_responses: got %0d expected 3", rsCnt); end
    if (hsCnt == 3 && rsCnt == 3) begin
      orderOk = 1; spacingOk = 1;
      for (int i = 0; i < 3; i++) begin
        if (gotRd[i] !== expRd[i] || rsN[i] - hsN[i] != 3) orderOk = 0;
        if (i > 0 && hsN[i] - hsN[i-1] != 4) spacingOk = 0;
      end
      cmpCnt++; if (!orderOk) begin errCnt++; $display("[TB] FAIL b2b_rsp_order: rdata %h %h %h expected %h %h %h", gotRd[0], gotRd[1], gotRd[2], expRd[0], expRd[1], expRd[2]); end
      cmpCnt++; if (!spacingOk) begin errCnt++; $display("[TB] FAIL b2b_spacing: hs at %0d %0d %0d expected step 4", hsN[0], hsN[1], hsN[2]); end
    end
    cmpCnt++; if (selRise !== 3 || selTot !== 6) begin errCnt++; $display("[TB] FAIL b2b_psel_shape: rises=%0d cycles=%0d expected 3/6", selRise, selTot); end
  endtask

  task automatic test_reset_mid_access();
    int spurious;
    spurious = 0;
    slvStall = 1'b1;
    @(posedge PCLK); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h9; cmd_wdata = 8'h00;
    @(negedge PCLK);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    cmpCnt++; if (PSELx !== 1'b1 || PENABLE !== 1'b1) begin errCnt++; $display("[TB] FAIL rma_in_access: psel=%b pen=%b expected 1/1", PSELx, PENABLE); end
    #2;
    PRESETn = 1'b0;
    #1;
    cmpCnt++; if (PSELx !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0) begin errCnt++; $display("[TB] FAIL rma_async_clear: psel=%b pen=%b rsp=%b expected 0/0/0", PSELx, PENABLE, rsp_valid); end
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge PCLK);
      if (rsp_valid) spurious++;
    end
    cmpCnt++; if (spurious !== 0 || cmd_ready !== 1'b1) begin errCnt++; $display("[TB] FAIL rma_no_response: rsp pulses=%0d ready=%b expected 0/1", spurious, cmd_ready); end
    slvStall = 1'b0; slvWait = 0; slvRdata = 8'h6B;
    runCmd(1'b0, 4'h9, 8'h00);
    cmpCnt++; if (!rGot || rLat !== 3 || rRdata !== 8'h6B || rErr !== 1'b0) begin errCnt++; $display("[TB] FAIL rma_new_read: got=%b lat=%0d rdata=%h err=%b expected 1/3/6B/0", rGot, rLat, rRdata, rErr); end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_one_wait();
    test_slave_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
